// File: rtl/voice_pkg.sv
// Shared types and defaults for the polyphonic voice allocator.
// Candidate classes are numbered so that a larger value means a better candidate.
package voice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_KILL   = 2'd2,
        ST_ASSIGN = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,
        CLS_GATED = 3'd1,
        CLS_REL   = 3'd2,
        CLS_FREE  = 3'd3,
        CLS_MATCH = 3'd4
    } cls_t;

    localparam int DEF_NUM_VOICES  = 8;
    localparam int DEF_NOTE_W      = 7;
    localparam int DEF_AGE_W       = 8;
    localparam int DEF_KILL_CYCLES = 4;

    // Raw class of one voice; stealing policy is applied by the caller.
    function automatic cls_t classify(input logic gate, input logic busy, input logic match);
        if (gate)
            return match ? CLS_MATCH : CLS_GATED;
        else if (busy)
            return CLS_REL;
        else
            return CLS_FREE;
    endfunction

endpackage

// File: rtl/voice_age_bank.sv
// Per-voice saturating age counters. On update the selected voice restarts
// at zero and every other voice ages by one, sticking at the maximum.
module voice_age_bank import voice_pkg::*; #(
    parameter int NUM_VOICES = DEF_NUM_VOICES,
    parameter int AGE_W      = DEF_AGE_W,
    parameter int IDX_W      = 3
) (
    input  logic                        Sys_clk,
    input  logic                        Sys_rst_n,
    input  logic [IDX_W-1:0]            clear_idx,
    input  logic                        update,
    output logic [NUM_VOICES*AGE_W-1:0] ages
);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    for (genvar i = 0; i < NUM_VOICES; i++) begin : g_age
        logic [AGE_W-1:0] age_q;

        // Restart the chosen voice, age the rest with saturation
        always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
            if (!Sys_rst_n)
                age_q <= '0;
            else if (update) begin
                if (clear_idx == IDX_W'(i))
                    age_q <= '0;
                else if (age_q != AGE_MAX)
                    age_q <= age_q + 1'b1;
            end
        end

        assign ages[i*AGE_W +: AGE_W] = age_q;
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: serially scans the voice slots for the best
// home for each key event, then gates, kills and retunes voices.
// Optional build macro: VOICE_STEAL_EN -- when defined, gated voices may be
// stolen; when undefined, a note-on with no usable voice is dropped.
module voice_allocator import voice_pkg::*; #(
    parameter int NUM_VOICES  = DEF_NUM_VOICES,
    parameter int NOTE_W      = DEF_NOTE_W,
    parameter int AGE_W       = DEF_AGE_W,
    parameter int KILL_CYCLES = DEF_KILL_CYCLES
) (
    input  logic                         Sys_clk,
    input  logic                         Sys_rst_n,
    input  logic                         Key_valid,
    output logic                         Key_ready,
    input  logic                         Key_on,
    input  logic [NOTE_W-1:0]            Key_note,
    input  logic [NUM_VOICES-1:0]        Voice_busy,
    output logic [NUM_VOICES-1:0]        Voice_gate,
    output logic [NUM_VOICES*NOTE_W-1:0] Voice_note,
    output logic [NUM_VOICES-1:0]        Voice_kill,
    output logic                         Steal_pulse,
    output logic                         Drop_pulse
);

    localparam int IDX_W  = (NUM_VOICES  > 1) ? $clog2(NUM_VOICES)  : 1;
    localparam int KCNT_W = (KILL_CYCLES > 1) ? $clog2(KILL_CYCLES) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VOICES - 1);
    localparam logic [KCNT_W-1:0] KILL_LAST = KCNT_W'(KILL_CYCLES - 1);

    state_t state_q, state_d;

    // Latched event and scan bookkeeping
    logic                on_q;
    logic [NOTE_W-1:0]   key_note_q;
    logic [IDX_W-1:0]    idx_q;
    logic [KCNT_W-1:0]   kcnt_q;
    cls_t                best_cls_q;
    logic [IDX_W-1:0]    best_idx_q;
    logic [AGE_W-1:0]    best_age_q;

    // Voice-facing registers
    logic [NUM_VOICES-1:0]             gate_q;
    logic [NUM_VOICES-1:0]             kill_q;
    logic [NUM_VOICES-1:0][NOTE_W-1:0] vnote_q;
    logic                              ready_q;
    logic                              drop_q;

    logic [NUM_VOICES*AGE_W-1:0]       ages;
    logic [NUM_VOICES-1:0][AGE_W-1:0]  age_v;

    // Scan comparator outputs
    logic             cur_match;
    logic             take;
    cls_t             cur_cls;
    cls_t             win_cls;
    logic [IDX_W-1:0] win_idx;
    logic [AGE_W-1:0] win_age;
    logic             accept;
    logic             scan_last;

    assign age_v = ages;

    voice_age_bank #(
        .NUM_VOICES (NUM_VOICES),
        .AGE_W      (AGE_W),
        .IDX_W      (IDX_W)
    ) u_age (
        .Sys_clk   (Sys_clk),
        .Sys_rst_n (Sys_rst_n),
        .clear_idx (best_idx_q),
        .update    (state_q == ST_ASSIGN),
        .ages      (ages)
    );

    assign accept    = (state_q == ST_IDLE) && Key_valid && ready_q;
    assign scan_last = (state_q == ST_SCAN) && (idx_q == LAST_IDX);

    // Classify the voice under the scan index and merge it into the running best
    always_comb begin
        cur_match = gate_q[idx_q] && (vnote_q[idx_q] == key_note_q);
        cur_cls   = classify(gate_q[idx_q], Voice_busy[idx_q], cur_match);
`ifndef VOICE_STEAL_EN
        if (cur_cls == CLS_GATED)
            cur_cls = CLS_NONE;
`endif
        // Only strictly better wins, so ties keep the lower index
        take = (cur_cls > best_cls_q) ||
               ((cur_cls == best_cls_q) &&
                ((cur_cls == CLS_REL) || (cur_cls == CLS_GATED)) &&
                (age_v[idx_q] > best_age_q));
        win_cls = take ? cur_cls       : best_cls_q;
        win_idx = take ? idx_q         : best_idx_q;
        win_age = take ? age_v[idx_q]  : best_age_q;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SCAN;
            ST_SCAN: begin
                if (idx_q == LAST_IDX) begin
                    if (!on_q || (win_cls == CLS_NONE))
                        state_d = ST_IDLE;
                    else if (win_cls >= CLS_FREE)
                        state_d = ST_ASSIGN;
                    else
                        state_d = ST_KILL;
                end
            end
            ST_KILL:   if (kcnt_q == KILL_LAST) state_d = ST_ASSIGN;
            ST_ASSIGN: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Event latch, scan index, best candidate and kill counter
    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            on_q       <= 1'b0;
            key_note_q <= '0;
            idx_q      <= '0;
            kcnt_q     <= '0;
            best_cls_q <= CLS_NONE;
            best_idx_q <= '0;
            best_age_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        on_q       <= Key_on;
                        key_note_q <= Key_note;
                        idx_q      <= '0;
                        best_cls_q <= CLS_NONE;
                        best_idx_q <= '0;
                        best_age_q <= '0;
                    end
                end
                ST_SCAN: begin
                    idx_q      <= idx_q + 1'b1;
                    best_cls_q <= win_cls;
                    best_idx_q <= win_idx;
                    best_age_q <= win_age;
                    kcnt_q     <= '0;
                end
                ST_KILL: kcnt_q <= kcnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    // Voice gate/note/kill registers and the handshake/status outputs
    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            gate_q  <= '0;
            kill_q  <= '0;
            vnote_q <= '0;
            ready_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            drop_q  <= 1'b0;
            // Ready lags IDLE entry by a cycle and drops on the accept edge
            ready_q <= (state_q == ST_IDLE) && !accept;
            if (scan_last) begin
                if (!on_q) begin
                    if (win_cls == CLS_MATCH)
                        gate_q[win_idx] <= 1'b0;
                end else if (win_cls == CLS_NONE) begin
                    drop_q <= 1'b1;
                end else if (win_cls <= CLS_REL) begin
                    gate_q[win_idx] <= 1'b0;
                    kill_q[win_idx] <= 1'b1;
                end
            end
            if ((state_q == ST_KILL) && (kcnt_q == KILL_LAST))
                kill_q <= '0;
            if (state_q == ST_ASSIGN) begin
                gate_q[best_idx_q]  <= 1'b1;
                vnote_q[best_idx_q] <= key_note_q;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    logic steal_q;

    // One-cycle flag when the kill target was still held by a key
    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n)
            steal_q <= 1'b0;
        else
            steal_q <= scan_last && on_q && (win_cls == CLS_GATED);
    end

    assign Steal_pulse = steal_q;
`else
    assign Steal_pulse = 1'b0;
`endif

    assign Key_ready  = ready_q;
    assign Voice_gate = gate_q;
    assign Voice_kill = kill_q;
    assign Voice_note = vnote_q;
    assign Drop_pulse = drop_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator (4 voices, 4 kill cycles, 8-bit ages).
// Stimulus pushes the expected end-of-event picture; a monitor measures
// latencies and pulses per event and compares when Key_ready returns.
module tb_voice_allocator;

    localparam int NV = 4;
    localparam int NW = 7;
    localparam int AW = 8;
    localparam int KC = 4;

    logic              Sys_clk = 1'b0;
    logic              Sys_rst_n = 1'b0;
    logic              Key_valid = 1'b0;
    logic              Key_on = 1'b0;
    logic [NW-1:0]     Key_note = '0;
    logic [NV-1:0]     Voice_busy = '0;
    logic              Key_ready;
    logic [NV-1:0]     Voice_gate;
    logic [NV-1:0]     Voice_kill;
    logic [NV*NW-1:0]  Voice_note;
    logic              Steal_pulse;
    logic              Drop_pulse;

    voice_allocator #(
        .NUM_VOICES  (NV),
        .NOTE_W      (NW),
        .AGE_W       (AW),
        .KILL_CYCLES (KC)
    ) dut (
        .Sys_clk     (Sys_clk),
        .Sys_rst_n   (Sys_rst_n),
        .Key_valid   (Key_valid),
        .Key_ready   (Key_ready),
        .Key_on      (Key_on),
        .Key_note    (Key_note),
        .Voice_busy  (Voice_busy),
        .Voice_gate  (Voice_gate),
        .Voice_note  (Voice_note),
        .Voice_kill  (Voice_kill),
        .Steal_pulse (Steal_pulse),
        .Drop_pulse  (Drop_pulse)
    );

    always #5 Sys_clk = ~Sys_clk;

    typedef struct {
        string            name;
        logic [NV-1:0]    gate;
        logic [NV*NW-1:0] note;
        int               gate_lat;
        int               ready_lat;
        logic [NV-1:0]    kill_or;
        int               kill_cyc;
        int               steal;
        int               drop_lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [NV*NW-1:0] nv(input int a, input int b, input int c, input int d);
        return {NW'(d), NW'(c), NW'(b), NW'(a)};
    endfunction

    // ---------------- monitor ----------------
    int            cyc = 0;
    int            acc_cyc = 0;
    bit            in_evt = 0;
    logic [NV-1:0] gate_prev = '0;
    logic [NV-1:0] k_or = '0;
    int            g_lat, k_cyc, st_cnt, d_lat, lat;
    exp_t          e;

    always @(posedge Sys_clk) begin
        cyc++;
        if (Sys_rst_n && Key_valid && Key_ready) begin
            acc_cyc = cyc;
            in_evt  = 1;
            g_lat   = 0;
            k_cyc   = 0;
            st_cnt  = 0;
            d_lat   = 0;
            k_or    = '0;
        end
    end

    always @(negedge Sys_clk) begin
        if (!Sys_rst_n) begin
            in_evt = 0;
        end else if (in_evt) begin
            lat = cyc - acc_cyc;
            if ((Voice_gate != gate_prev) && (g_lat == 0)) g_lat = lat;
            if (|Voice_kill) begin
                k_cyc++;
                k_or |= Voice_kill;
            end
            if (Steal_pulse) st_cnt++;
            if (Drop_pulse && (d_lat == 0)) d_lat = lat;
            if (Key_ready) begin
                in_evt = 0;
                if (sb.size() == 0) begin
                    chk("unexpected_event", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, ".gate"},      Voice_gate, e.gate);
                    chk({e.name, ".note"},      Voice_note, e.note);
                    chk({e.name, ".gate_lat"},  g_lat,      e.gate_lat);
                    chk({e.name, ".ready_lat"}, lat,        e.ready_lat);
                    chk({e.name, ".kill_mask"}, k_or,       e.kill_or);
                    chk({e.name, ".kill_cyc"},  k_cyc,      e.kill_cyc);
                    chk({e.name, ".steal"},     st_cnt,     e.steal);
                    chk({e.name, ".drop_lat"},  d_lat,      e.drop_lat);
                end
            end else if (lat > 40) begin
                chk("ready_timeout", lat, 0);
                in_evt = 0;
                if (sb.size() != 0) void'(sb.pop_front());
            end
        end
        gate_prev = Voice_gate;
    end

    // ---------------- stimulus ----------------
    task automatic send(input bit on, input int note, input logic [NV-1:0] busy);
        int t;
        t = 0;
        @(negedge Sys_clk);
        while (!Key_ready && (t < 100)) begin
            @(negedge Sys_clk);
            t++;
        end
        if (t >= 100) chk("send_wait_ready", 0, 1);
        Voice_busy = busy;
        Key_on     = on;
        Key_note   = NW'(note);
        Key_valid  = 1'b1;
        @(posedge Sys_clk);
        #1 Key_valid = 1'b0;
    endtask

    task automatic ev(input string name, input bit on, input int note, input logic [NV-1:0] busy,
                      input logic [NV-1:0] gate, input logic [NV*NW-1:0] nvec,
                      input int glat, input int rlat, input logic [NV-1:0] kor,
                      input int kcyc, input int stl, input int dlat);
        exp_t x;
        x.name = name; x.gate = gate; x.note = nvec; x.gate_lat = glat;
        x.ready_lat = rlat; x.kill_or = kor; x.kill_cyc = kcyc;
        x.steal = stl; x.drop_lat = dlat;
        sb.push_back(x);
        send(on, note, busy);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (((sb.size() != 0) || in_evt || !Key_ready) && (t < 200)) begin
            @(negedge Sys_clk);
            t++;
        end
        if (t >= 200) chk("wait_idle_timeout", t, 0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t;
        logic [NW-1:0] n2;

        // Reset state
        repeat (3) @(negedge Sys_clk);
        chk("rst.ready", Key_ready,   0);
        chk("rst.gate",  Voice_gate,  0);
        chk("rst.note",  Voice_note,  0);
        chk("rst.kill",  Voice_kill,  0);
        chk("rst.steal", Steal_pulse, 0);
        chk("rst.drop",  Drop_pulse,  0);
        Sys_rst_n = 1'b1;
        @(posedge Sys_clk);
        #1 chk("rst.ready_after_release", Key_ready, 1);

        // Fill three voices from an idle bank
        ev("fill60", 1, 60, 4'b0000, 4'b0001, nv(60, 0, 0, 0),  5, 6, 4'b0000, 0, 0, 0);
        ev("fill62", 1, 62, 4'b0000, 4'b0011, nv(60, 62, 0, 0), 5, 6, 4'b0000, 0, 0, 0);
        ev("fill64", 1, 64, 4'b0000, 4'b0111, nv(60, 62, 64, 0), 5, 6, 4'b0000, 0, 0, 0);
        // Re-press of a held note: no kill, no gate change
        ev("repress62", 1, 62, 4'b0000, 4'b0111, nv(60, 62, 64, 0), 0, 6, 4'b0000, 0, 0, 0);
        wait_idle();
        chk("ages_after_repress", dut.ages, {8'd4, 8'd1, 8'd0, 8'd3});
        // Note-off for a note nobody holds
        ev("off99", 0, 99, 4'b0000, 4'b0111, nv(60, 62, 64, 0), 0, 5, 4'b0000, 0, 0, 0);
        ev("fill65", 1, 65, 4'b0000, 4'b1111, nv(60, 62, 64, 65), 5, 6, 4'b0000, 0, 0, 0);
        // Release voice 0, then reuse it while its envelope still rings
        ev("off60", 0, 60, 4'b1111, 4'b1110, nv(60, 62, 64, 65), 4, 5, 4'b0000, 0, 0, 0);
        ev("rel67", 1, 67, 4'b1111, 4'b1111, nv(67, 62, 64, 65), 9, 10, 4'b0001, 4, 0, 0);
`ifdef VOICE_STEAL_EN
        // All gated: oldest (voice 2, age 3) is stolen
        ev("steal72", 1, 72, 4'b1111, 4'b1111, nv(67, 62, 72, 65), 4, 10, 4'b0100, 4, 1, 0);
        n2 = NW'(72);
`else
        // All gated and stealing disabled: drop with no state change
        ev("drop50", 1, 50, 4'b1111, 4'b1111, nv(67, 62, 64, 65), 0, 5, 4'b0000, 0, 0, 4);
        n2 = NW'(64);
`endif
        ev("off62", 0, 62, 4'b1111, 4'b1101, nv(67, 62, int'(n2), 65), 4, 5, 4'b0000, 0, 0, 0);
        wait_idle();

        // Reset in the 2nd kill cycle of a note-on that reuses voice 1
        send(1, 70, 4'b1111);
        t = 0;
        while ((Voice_kill == '0) && (t < 50)) begin
            @(negedge Sys_clk);
            t++;
        end
        chk("midkill.kill_seen", Voice_kill, 4'b0010);
        @(posedge Sys_clk);
        #2 Sys_rst_n = 1'b0;
        #1;
        chk("midkill.gate",  Voice_gate,  0);
        chk("midkill.kill",  Voice_kill,  0);
        chk("midkill.note",  Voice_note,  0);
        chk("midkill.ready", Key_ready,   0);
        chk("midkill.steal", Steal_pulse, 0);
        chk("midkill.drop",  Drop_pulse,  0);
        @(negedge Sys_clk);
        @(negedge Sys_clk);
        Sys_rst_n = 1'b1;
        @(posedge Sys_clk);
        #1;
        chk("midkill.ready_after_release", Key_ready, 1);
        chk("midkill.gate_after_release",  Voice_gate, 0);

        // Equal-age ties among ringing voices go to the lower index
        ev("tie40", 1, 40, 4'b1111, 4'b0001, nv(40, 0, 0, 0),  9, 10, 4'b0001, 4, 0, 0);
        ev("tie41", 1, 41, 4'b1111, 4'b0011, nv(40, 41, 0, 0), 9, 10, 4'b0010, 4, 0, 0);
        wait_idle();

        if (sb.size() != 0) chk("scoreboard_pending", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
